axi_hp_ddr_slave_model: RTL and testbench

- AXI4 full slave memory model standing in for DDR behind the accelerator's HP master port.
- Backing store is an array `memory` of 32-bit words, preloaded and read back hierarchically by the bench.
- Serves INCR bursts on independent read and write channels.
- Throttles beat rate with a credit-based bandwidth limiter to emulate finite DDR bandwidth.

---
 rtl/axi_hp_ddr_slave_model.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_hp_ddr_slave_model.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hp_ddr_slave_model.sv
// rtl/axi_hp_ddr_slave_model.sv - AXI4 slave memory model with credit-based bandwidth throttling
module axi_hp_ddr_slave_model #(
  parameter int S_AXI_ID_WIDTH   = 4,
  parameter int S_AXI_DATA_WIDTH = 256,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int BW_div_FREQ_100  = 1300,
  parameter int MEM_WORDS        = 2**22
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWLOCK,
  input  logic [3:0]                    S_AXI_AWCACHE,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic [3:0]                    S_AXI_AWQOS,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARLOCK,
  input  logic [3:0]                    S_AXI_ARCACHE,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic [3:0]                    S_AXI_ARQOS,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int          BEAT_WORDS = S_AXI_DATA_WIDTH / 32;
  localparam int          BEAT_BYTES = S_AXI_DATA_WIDTH / 8;
  localparam int          MEM_AW     = $clog2(MEM_WORDS);
  localparam logic [31:0] COST       = 32'(BEAT_BYTES * 100);
  localparam logic [31:0] CREDIT_CAP = 32'(2 * BEAT_BYTES * 100);
  localparam logic [31:0] CREDIT_INC = 32'(BW_div_FREQ_100);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Backing store; never reset so bench preloads survive
  logic [31:0] memory [MEM_WORDS];

  logic [1:0]        w_state;
  logic [MEM_AW-1:0] w_ptr;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic [31:0]       wcredit;
  logic              w_fire;

  logic [0:0]        r_state;
  logic [MEM_AW-1:0] r_ptr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic              r_all_issued;
  logic [31:0]       rcredit;
  logic              r_issue;
  logic              r_fire;

  // Byte addresses become word indices; the index wraps at MEM_WORDS (power of two)
  logic [S_AXI_ADDR_WIDTH-3:0] aw_word;
  logic [S_AXI_ADDR_WIDTH-3:0] ar_word;
  assign aw_word = S_AXI_AWADDR[S_AXI_ADDR_WIDTH-1:2];
  assign ar_word = S_AXI_ARADDR[S_AXI_ADDR_WIDTH-1:2];

  // Burst type/size/cache attributes have no effect on this model
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK, S_AXI_AWCACHE,
                           S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_ARSIZE, S_AXI_ARBURST,
                           S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                           S_AXI_WLAST, aw_word, ar_word,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Per-cycle credit refill, less any spend, saturating at two beats of headroom
  function automatic logic [31:0] credit_next(input logic [31:0] credit, input logic spend);
    logic [31:0] sum;
    sum = credit + CREDIT_INC - (spend ? COST : 32'd0);
    return (sum > CREDIT_CAP) ? CREDIT_CAP : sum;
  endfunction

  assign S_AXI_AWREADY = (w_state == W_IDLE) && !S_AXI_ARESET;
  assign S_AXI_WREADY  = (w_state == W_DATA) && (wcredit >= COST) && !S_AXI_ARESET;
  assign S_AXI_ARREADY = (r_state == R_IDLE) && !S_AXI_ARESET;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;

  assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
  assign r_fire  = S_AXI_RVALID && S_AXI_RREADY;
  // A new beat may be registered when the output slot is empty or being drained this cycle
  assign r_issue = (r_state == R_DATA) && !r_all_issued &&
                   (!S_AXI_RVALID || S_AXI_RREADY) && (rcredit >= COST);

  // Byte-masked write of one beat into consecutive words
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_fire) begin
      for (int j = 0; j < BEAT_WORDS; j++) begin
        for (int b = 0; b < 4; b++) begin
          if (S_AXI_WSTRB[4*j+b]) begin
            memory[w_ptr + MEM_AW'(j)][8*b +: 8] <= S_AXI_WDATA[32*j+8*b +: 8];
          end
        end
      end
    end
  end

  // Write channel: accept address, take len+1 beats, then hold the response
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state      <= W_IDLE;
      w_ptr        <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      wcredit      <= '0;
      S_AXI_BID    <= '0;
      S_AXI_BVALID <= 1'b0;
    end else begin
      wcredit <= credit_next(wcredit, w_fire);
      case (w_state)
        W_IDLE: begin
          if (S_AXI_AWVALID) begin
            S_AXI_BID <= S_AXI_AWID;
            w_ptr     <= aw_word[MEM_AW-1:0];
            w_len     <= S_AXI_AWLEN;
            w_cnt     <= '0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_ptr <= w_ptr + MEM_AW'(BEAT_WORDS);
            w_cnt <= w_cnt + 8'd1;
            // Beat count, not WLAST, terminates the burst
            if (w_cnt == w_len) begin
              S_AXI_BVALID <= 1'b1;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: accept address, issue credit-paced beats held stable until taken
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state      <= R_IDLE;
      r_ptr        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_all_issued <= 1'b0;
      rcredit      <= '0;
      S_AXI_RID    <= '0;
      S_AXI_RDATA  <= '0;
      S_AXI_RLAST  <= 1'b0;
      S_AXI_RVALID <= 1'b0;
    end else begin
      rcredit <= credit_next(rcredit, r_issue);
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            S_AXI_RID    <= S_AXI_ARID;
            r_ptr        <= ar_word[MEM_AW-1:0];
            r_len        <= S_AXI_ARLEN;
            r_cnt        <= '0;
            r_all_issued <= 1'b0;
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_issue) begin
            for (int j = 0; j < BEAT_WORDS; j++) begin
              S_AXI_RDATA[32*j +: 32] <= memory[r_ptr + MEM_AW'(j)];
            end
            S_AXI_RVALID <= 1'b1;
            S_AXI_RLAST  <= (r_cnt == r_len);
            r_ptr        <= r_ptr + MEM_AW'(BEAT_WORDS);
            r_cnt        <= r_cnt + 8'd1;
            if (r_cnt == r_len) begin
              r_all_issued <= 1'b1;
            end
          end else if (r_fire) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RLAST  <= 1'b0;
          end
          if (r_fire && S_AXI_RLAST) begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_hp_ddr_slave_model.sv
// tb/tb_axi_hp_ddr_slave_model.sv - directed self-checking bench for axi_hp_ddr_slave_model
module tb_axi_hp_ddr_slave_model;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid, awready;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  logic [31:0]  f_araddr;
  logic [7:0]   f_arlen;
  logic         f_arvalid, f_arready, f_rready;
  logic [3:0]   f_rid, f_bid;
  logic [255:0] f_rdata;
  logic [1:0]   f_rresp, f_bresp;
  logic         f_rlast, f_rvalid, f_awready, f_wready, f_bvalid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [255:0] rd_data [16];
  logic         rd_last [16];
  logic [3:0]   rd_id;
  int           rd_beats;
  int           rd_lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_hp_ddr_slave_model #(.MEM_WORDS(2**24)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(3'd5), .S_AXI_AWBURST(2'd1), .S_AXI_AWLOCK(1'b0),
    .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWQOS(4'd0),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(3'd5), .S_AXI_ARBURST(2'd1), .S_AXI_ARLOCK(1'b0),
    .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  axi_hp_ddr_slave_model #(.BW_div_FREQ_100(3200), .MEM_WORDS(1024)) dut_fast (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWID(4'd0), .S_AXI_AWADDR(32'd0), .S_AXI_AWLEN(8'd0),
    .S_AXI_AWSIZE(3'd5), .S_AXI_AWBURST(2'd1), .S_AXI_AWLOCK(1'b0),
    .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWQOS(4'd0),
    .S_AXI_AWVALID(1'b0), .S_AXI_AWREADY(f_awready),
    .S_AXI_WDATA(256'd0), .S_AXI_WSTRB(32'd0), .S_AXI_WLAST(1'b0),
    .S_AXI_WVALID(1'b0), .S_AXI_WREADY(f_wready),
    .S_AXI_BID(f_bid), .S_AXI_BRESP(f_bresp), .S_AXI_BVALID(f_bvalid), .S_AXI_BREADY(1'b0),
    .S_AXI_ARID(4'd6), .S_AXI_ARADDR(f_araddr), .S_AXI_ARLEN(f_arlen),
    .S_AXI_ARSIZE(3'd5), .S_AXI_ARBURST(2'd1), .S_AXI_ARLOCK(1'b0),
    .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0),
    .S_AXI_ARVALID(f_arvalid), .S_AXI_ARREADY(f_arready),
    .S_AXI_RID(f_rid), .S_AXI_RDATA(f_rdata), .S_AXI_RRESP(f_rresp), .S_AXI_RLAST(f_rlast),
    .S_AXI_RVALID(f_rvalid), .S_AXI_RREADY(f_rready)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat k of a pattern: word j = seed + step*(8k+j)
  function automatic logic [255:0] beat_data(input logic [31:0] seed, input logic [31:0] step, input int k);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = seed + step * 32'(8*k + j);
    return r;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [31:0] seed, input logic [31:0] step, input logic [31:0] strb);
    int n;
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check("aw handshake", 256'(n < 50), 256'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      wdata = beat_data(seed, step, k); wstrb = strb; wlast = (k == len); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      check($sformatf("w beat%0d handshake", k), 256'(n < 50), 256'd1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check("bvalid seen", 256'(bvalid), 256'd1);
    check("bid", 256'(bid), 256'(id));
    check("bresp", 256'(bresp), 256'd0);
    @(negedge clk);
    check("single bvalid", 256'(bvalid), 256'd0);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int stall_at);
    int n, t0;
    logic [255:0] sd;
    logic sl;
    bit stalled;
    stalled = 1'b0;
    rd_lat = -1;
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check("ar handshake", 256'(n < 50), 256'd1);
    t0 = cyc + 1;
    @(negedge clk);
    arvalid = 1'b0;
    rd_beats = 0; n = 0;
    while (rd_beats <= len && n < 400) begin
      if (rvalid && rd_beats == stall_at && !stalled) begin
        rready = 1'b0; sd = rdata; sl = rlast; stalled = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("hold rvalid", 256'(rvalid), 256'd1);
          check("hold rdata", rdata, sd);
          check("hold rlast", 256'(rlast), 256'(sl));
        end
        rready = 1'b1;
      end
      if (rvalid) begin
        rd_data[rd_beats] = rdata; rd_last[rd_beats] = rlast; rd_id = rid;
        check("rresp", 256'(rresp), 256'd0);
        if (rlast) rd_lat = cyc + 1 - t0;
        rd_beats++;
      end
      @(negedge clk);
      n++;
    end
    check("rd beat count", 256'(rd_beats), 256'(len + 1));
    check("rvalid after burst", 256'(rvalid), 256'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    f_araddr = '0; f_arlen = '0; f_arvalid = 1'b0; f_rready = 1'b0;
    dut.memory[5] = 32'hA5A5_0001;

    // Reset: outputs low during reset, readies up on the first cycle after release
    @(posedge clk); @(negedge clk);
    check("awready in reset", 256'(awready), 256'd0);
    check("arready in reset", 256'(arready), 256'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("awready after reset", 256'(awready), 256'd1);
    check("arready after reset", 256'(arready), 256'd1);
    check("bvalid after reset", 256'(bvalid), 256'd0);
    check("rvalid after reset", 256'(rvalid), 256'd0);
    check("wready after reset", 256'(wready), 256'd0);
    check("rlast after reset", 256'(rlast), 256'd0);
    check("preload survives", 256'(dut.memory[5]), 256'(32'hA5A5_0001));
    @(negedge clk);

    // Masked single-beat write: only word 0 strobed
    for (int j = 0; j < 8; j++) dut.memory[32'h0080_0000 + j] = 32'hDEAD_0000 + 32'(j);
    do_write(4'hB, 32'h0200_0000, 0, 32'h1111_1111, 32'd0, 32'h0000_000F);
    check("masked word0", 256'(dut.memory[32'h0080_0000]), 256'(32'h1111_1111));
    for (int j = 1; j < 8; j++)
      check($sformatf("masked word%0d", j), 256'(dut.memory[32'h0080_0000 + j]), 256'(32'hDEAD_0000 + 32'(j)));

    // 4-beat burst read of memory[i] = i
    for (int i = 0; i < 128; i++) dut.memory[i] = 32'(i);
    do_read(4'h9, 32'h0, 3, -1);
    check("rid", 256'(rd_id), 256'h9);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd4 beat%0d", k), rd_data[k], beat_data(32'd0, 32'd1, k));
      check($sformatf("rd4 rlast%0d", k), 256'(rd_last[k]), 256'(k == 3));
    end

    // Backpressure: RREADY low 5 cycles while beat 3 of 8 is presented
    do_read(4'h2, 32'h0, 7, 3);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bp beat%0d", k), rd_data[k], beat_data(32'd0, 32'd1, k));
      check($sformatf("bp rlast%0d", k), 256'(rd_last[k]), 256'(k == 7));
    end

    // Concurrent 8-beat write and 8-beat read on disjoint regions
    fork
      do_write(4'h4, 32'h0100_0000, 7, 32'h7000_0000, 32'd1, 32'hFFFF_FFFF);
      do_read(4'h5, 32'h0, 7, -1);
    join
    for (int k = 0; k < 8; k++)
      check($sformatf("conc rd beat%0d", k), rd_data[k], beat_data(32'd0, 32'd1, k));
    do_read(4'h5, 32'h0100_0000, 7, -1);
    for (int k = 0; k < 8; k++)
      check($sformatf("conc wr readback%0d", k), rd_data[k], beat_data(32'h7000_0000, 32'd1, k));

    // Throttling at 13 bytes/cycle from zero credit: last beat ~40 cycles after AR
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_read(4'h3, 32'h0, 15, -1);
    check($sformatf("throttle latency=%0d in 38..42", rd_lat), 256'(rd_lat >= 38 && rd_lat <= 42), 256'd1);
    check("throttle beat0", rd_data[0], beat_data(32'd0, 32'd1, 0));
    check("throttle beat15", rd_data[15], beat_data(32'd0, 32'd1, 15));
    check("throttle rlast15", 256'(rd_last[15]), 256'd1);

    // Full-rate instance: 16 back-to-back beats
    f_araddr = 32'h0; f_arlen = 8'd15; f_arvalid = 1'b1; f_rready = 1'b1;
    n = 0;
    while (!f_arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    f_arvalid = 1'b0;
    n = 0;
    while (!f_rvalid && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("fast rvalid%0d", k), 256'(f_rvalid), 256'd1);
      check($sformatf("fast rlast%0d", k), 256'(f_rlast), 256'(k == 15));
      @(negedge clk);
    end
    check("fast done", 256'(f_rvalid), 256'd0);
    check("fast rid", 256'(f_rid), 256'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
